// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, widths and the rotate-priority pick function for the mux4 round-robin arbiter.
package mux4_arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Returns {found, idx}: first set req bit scanning start, start+1, ... (mod 4).
    function automatic logic [ARB_IDX_W:0] rr_pick(input logic [ARB_N-1:0] req,
                                                   input logic [ARB_IDX_W-1:0] start);
        logic                 found;
        logic                 hit;
        logic [ARB_IDX_W-1:0] idx;
        logic [ARB_IDX_W-1:0] cand;
        found = 1'b0;
        idx   = {ARB_IDX_W{1'b0}};
        for (int i = 0; i < ARB_N; i++) begin
            cand  = start + ARB_IDX_W'(i);
            hit   = !found && req[cand];
            idx   = hit ? cand : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between four requesters and the mux4 arbiter.
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    logic [ARB_N-1:0] req;
    logic [ARB_N-1:0] gnt;
    logic             s0;
    logic             s1;
    logic             valid;

    modport master (output req, input gnt, input s0, input s1, input valid);
    modport slave  (input req, output gnt, output s0, output s1, output valid);

endinterface

// File: rtl/mux4_rr_arbiter_prio4.sv
// Combinational rotate-priority encoder: first requester at or after start wins.
module rr_prio4
    import mux4_arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] start,
    output logic                 found,
    output logic [ARB_IDX_W-1:0] idx
);

    assign {found, idx} = rr_pick(req, start);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner/select sequencer in front of mux4_1; s1/s0 drive the mux select directly.
// Optional per-owner hold limit is built when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    arb_state_e           state_r;
    arb_state_e           nxt_state_s;
    logic [ARB_IDX_W-1:0] own_r;
    logic [ARB_IDX_W-1:0] last_r;
    logic [ARB_IDX_W-1:0] nxt_own_s;
    logic [ARB_IDX_W-1:0] start_s;
    logic                 take_s;
    logic                 pick_found_s;
    logic [ARB_IDX_W-1:0] pick_idx_s;
    logic                 others_s;
    logic                 timeout_s;
    logic [ARB_N-1:0]     gnt_r;
    logic                 s0_r;
    logic                 s1_r;
    logic                 valid_r;

    // While granted last_r equals own_r, so one search start serves both the IDLE and release paths.
    assign start_s  = last_r + 2'd1;
    assign others_s = |(bus.req & ~gnt_r);

    rr_prio4 u_prio (
        .req   (bus.req),
        .start (start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_r;

    assign timeout_s = (hold_cnt_r == HOLD_LIM) && others_s;

    // Hold counter: cleared on each new owner, saturating at HOLD_MAX-1 while ownership continues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (take_s) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r == ARB_GRANT) && (hold_cnt_r != HOLD_LIM)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end
    end
`else
    // HOLD_MAX only matters with the hold limit built in.
    logic unused_hold_max_s;
    assign unused_hold_max_s = ^32'(HOLD_MAX);
    assign timeout_s         = 1'b0;
`endif

    // Next-state / next-owner selection.
    always_comb begin
        nxt_state_s = state_r;
        nxt_own_s   = own_r;
        take_s      = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    nxt_state_s = ARB_GRANT;
                    nxt_own_s   = pick_idx_s;
                    take_s      = 1'b1;
                end else begin
                    nxt_state_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (bus.req[own_r] && !timeout_s) begin
                    nxt_state_s = ARB_GRANT;
                end else if (pick_found_s) begin
                    nxt_state_s = ARB_GRANT;
                    nxt_own_s   = pick_idx_s;
                    take_s      = 1'b1;
                end else begin
                    nxt_state_s = ARB_IDLE;
                end
            end
            default: begin
                nxt_state_s = ARB_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; select holds its value while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            own_r   <= 2'd0;
            last_r  <= 2'd3;
            gnt_r   <= 4'b0000;
            s0_r    <= 1'b0;
            s1_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            own_r   <= nxt_own_s;
            if (take_s) begin
                last_r <= nxt_own_s;
            end
            if (nxt_state_s == ARB_GRANT) begin
                gnt_r   <= 4'b0001 << nxt_own_s;
                s0_r    <= nxt_own_s[0];
                s1_r    <= nxt_own_s[1];
                valid_r <= 1'b1;
            end else begin
                gnt_r   <= 4'b0000;
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.s0    = s0_r;
    assign bus.s1    = s1_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural model pushes expected {gnt,s1,s0,valid} per cycle.
module tb_mux4_rr_arbiter;

    localparam int HM = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus();

    mux4_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] sb_q[$];
    bit         m_busy;
    int         m_own;
    int         m_last;
    int         m_cnt;
    logic [1:0] m_sel;

    // Drive one cycle of stimulus, advance the model, push its expectation, then step past the edge.
    task automatic tick(input logic r, input logic [3:0] rq);
        int  start;
        int  idx;
        bit  found;
        bit  others;
        rst_n   = r;
        bus.req = rq;
        if (!r) begin
            m_busy = 1'b0; m_own = 0; m_last = 3; m_cnt = 0; m_sel = 2'b00;
        end else begin
            others = (rq & ~(4'(1 << m_own))) != 4'b0000;
            if (m_busy && rq[m_own] && !(TO_EN && (m_cnt == HM - 1) && others)) begin
                if (m_cnt < HM - 1) m_cnt = m_cnt + 1;
            end else begin
                start = m_busy ? m_own : m_last;
                found = 1'b0;
                idx   = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && rq[(start + k) % 4]) begin
                        found = 1'b1;
                        idx   = (start + k) % 4;
                    end
                end
                if (found) begin
                    m_busy = 1'b1; m_own = idx; m_last = idx; m_cnt = 0; m_sel = idx[1:0];
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        sb_q.push_back({(m_busy ? 4'(1 << m_own) : 4'b0000), m_sel, m_busy});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick(i < 3 ? 1'b0 : 1'b1, 4'b1111);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset[%0d] got=%b want=%b", i, obs, exp);
            end
            checks++;
            if (i < 3 && obs !== 7'b0000000) begin
                failures++;
                $display("FAIL reset_outputs[%0d] got=%b want=0000000", i, obs);
            end
        end
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant got=%b want=0001", bus.gnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] rq [4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1, rq[i]);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single[%0d] got=%b want=%b", i, obs, exp);
            end
            if (i == 2) begin
                checks++;
                if (obs !== 7'b0100_10_1) begin
                    failures++;
                    $display("FAIL single_grant got=%b want=0100101", obs);
                end
            end
        end
        checks++;
        if ({bus.gnt, bus.s1, bus.s0, bus.valid} !== 7'b0000_10_0) begin
            failures++;
            $display("FAIL single_release got=%b want=0000100", {bus.gnt, bus.s1, bus.s0, bus.valid});
        end
    endtask

    task automatic test_fairness();
        logic [3:0] rq   [6] = '{4'b0000, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] want [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 6; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1, rq[i]);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fair[%0d] got=%b want=%b", i, obs, exp);
            end
            checks++;
            if (bus.gnt !== want[i] || $countones(bus.gnt) > 1) begin
                failures++;
                $display("FAIL fair_order[%0d] got=%b want=%b", i, bus.gnt, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq [4] = '{4'b0000, 4'b0010, 4'b1011, 4'b1001};
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1, rq[i]);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL handoff[%0d] got=%b want=%b", i, obs, exp);
            end
        end
        checks++;
        if ({bus.gnt, bus.s1, bus.s0, bus.valid} !== 7'b1000_11_1) begin
            failures++;
            $display("FAIL handoff_direct got=%b want=1000111", {bus.gnt, bus.s1, bus.s0, bus.valid});
        end
    endtask

    task automatic test_mid_reset();
        logic       rs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick(rs[i], 4'b0100);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midreset[%0d] got=%b want=%b", i, obs, exp);
            end
            if (i == 2) begin
                checks++;
                if (obs !== 7'b0000000) begin
                    failures++;
                    $display("FAIL midreset_clear got=%b want=0000000", obs);
                end
            end
        end
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL midreset_regrant got=%b want=0100", bus.gnt);
        end
    endtask

`ifdef MUX4_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [6:0] exp;
        logic [6:0] obs;
        for (int i = 0; i < 7; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1, i == 1 ? 4'b0001 : 4'b0101);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, obs, exp);
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (bus.gnt !== (i == 4 ? 4'b0001 : 4'b0100)) begin
                    failures++;
                    $display("FAIL timeout_edge[%0d] got=%b", i, bus.gnt);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1, 4'b0001);
            exp = sb_q.pop_front();
            obs = {bus.gnt, bus.s1, bus.s0, bus.valid};
            checks++;
            if (obs !== exp || (i > 0 && bus.gnt !== 4'b0001)) begin
                failures++;
                $display("FAIL timeout_alone[%0d] got=%b want=%b", i, obs, exp);
            end
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_mid_reset();
`ifdef MUX4_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select sequencer for the 4:1 single-bit mux (`mux4_1`), which shares one output path between four requesters. The block takes four request lines and issues one-hot grants. It drives the mux select pair `{s1,s0}` to the current owner's index and holds ownership until that owner drops its request. It sits directly in front of `mux4_1`: its `s0`/`s1` connect straight to the mux select inputs.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum consecutive grant cycles per owner. Used only when `MUX4_ARB_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset is synchronous and active-low, sampled on `clk` rising edge.
- `req`, input, 4: request lines. `req[k]` requests mux input k, where k=0..3 maps to a,b,c,d.
- `gnt`, output, 4: one-hot grant, registered; all zero when idle.
- `s0`, output, 1: mux select LSB, equal to owner index bit 0, registered.
- `s1`, output, 1: mux select MSB, equal to owner index bit 1, registered.
- `valid`, output, 1: high whenever `gnt` is non-zero, meaning the mux output is owned.

## Operation
- **States:**
  - IDLE: no owner.
  - GRANT: one owner, index `own[1:0]`.
- **Round-robin pointer `last[1:0]`:** index of the most recent owner; reset value 3, so the first search starts at index 0.
- **Search order:** `last+1, last+2, last+3, last` (mod 4). The first set `req` bit in that order wins.
- **IDLE transitions:**
  - If `req` is non-zero, go to GRANT with `own = winner` and `last = winner`.
  - Otherwise stay in IDLE.
- **GRANT transitions:**
  - If `req[own]` = 1, hold: no change.
  - If `req[own]` = 0 and other requests are pending, hand off directly to the winner with no idle gap. The search starts from `own+1`.
  - If `req[own]` = 0 and no requests are pending, go to IDLE.
- **Outputs, all registered from next state:**
  - `gnt = 1<<own` in GRANT, 0 in IDLE.
  - `{s1,s0} = own` in GRANT.
  - In IDLE, `{s1,s0}` holds its last value so the mux path stays glitch-free.
- **Reset (`rst_n`=0 at an edge):** forces IDLE with `gnt`=0, `s0`=0, `s1`=0, `valid`=0, `last`=3 and hold counter 0. This applies mid-grant: ownership is lost, with no completion.
- **Request behaviour:** requesters keep `req` high until granted. Dropping `req` before the grant is legal and simply withdraws the request.
- **Simultaneous release and new request by the same requester:** the bit is sampled low, so the handoff goes to others first. Index `own` is searched last.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N gives `gnt`/`s0`/`s1`/`valid` updated after edge N, visible in cycle N+1.
- **Release latency:** `req[own]` sampled low at edge N gives the new `gnt` in cycle N+1, so there is exactly one cycle of handoff.
- **Select alignment:** `s0`/`s1` change on the same edge as `gnt`. The mux output `y` for the new owner is valid combinationally in the same cycle.
- **Throughput:** one ownership change per cycle at most.
- **Exclusivity:** no cycle ever has more than one `gnt` bit set.

## Configuration
- **`MUX4_ARB_TIMEOUT_EN` defined:**
  - An 8-bit hold counter clears on every grant or handoff and increments each GRANT cycle.
  - When the counter reaches `HOLD_MAX-1` and any other `req` bit is set, the next edge forces a handoff exactly as on release. The current owner keeps requesting and is re-eligible in round-robin order.
  - If no other request is pending, the counter saturates at `HOLD_MAX-1` and ownership continues.
- **Macro undefined:** no counter logic is built, `HOLD_MAX` is ignored, and ownership lasts until release with no time bound.

## Structure
- **Shared package `mux4_arb_pkg`:**
  - State enum (`ARB_IDLE`, `ARB_GRANT`).
  - Width constants `ARB_N=4` and `ARB_IDX_W=2`.
  - Function `rr_pick(req, start)` returning `{found, idx}`.
- **One sub-module `rr_prio4`:** combinational rotate-priority encoder (req[3:0], start[1:0] -> found, idx[1:0]). It is instantiated once and shared by the IDLE and release paths.
- **Top block:** state register, `own`/`last` registers, output registers, and the optional hold counter.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=4'b1111 -> `gnt`=0, `s0`=`s1`=0, `valid`=0 throughout. After release, the first grant is `gnt`=4'b0001 one cycle later.
- **Single request:** `req`=4'b0100 from IDLE -> next cycle `gnt`=4'b0100, `{s1,s0}`=2'b10, `valid`=1. Drop `req` -> next cycle `gnt`=0, `valid`=0, `{s1,s0}` still 2'b10.
- **Fairness:** hold `req`=4'b1111 and pulse each owner's bit low for one cycle on grant -> grant order 0,1,2,3,0 with one-cycle handoffs. Never two `gnt` bits set.
- **Direct handoff:** owner 1, `req`=4'b1011, then drop bit 1 -> next cycle `gnt`=4'b1000 (index 3 before 0), with no IDLE cycle.
- **Mid-grant reset:** owner 2, assert `rst_n`=0 for one cycle -> next cycle all outputs at reset values. After reset, `req`=4'b0100 is granted in the following cycle.
- **Timeout (with `MUX4_ARB_TIMEOUT_EN`, `HOLD_MAX`=4):**
  - Owner 0 holds `req`, `req[2]`=1 -> `gnt` moves to 4'b0100 after exactly 4 grant cycles.
  - Same case without any other requester -> owner 0 keeps its grant indefinitely.
